// File: rtl/riscv_pkg.sv
// Shared defaults and IF/ID control encoding for the fetch front end.
package riscv_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam int          PC_STEP_DEF   = 4;

  typedef enum logic [1:0] {
    IFID_LOAD  = 2'd0,
    IFID_HOLD  = 2'd1,
    IFID_CLEAR = 2'd2
  } ifid_op_e;

  // A missing memory response becomes a bubble, same as a flush.
  function automatic ifid_op_e ifid_op(
    input logic flush,
    input logic stall,
    input logic ready
  );
    if (flush)       return IFID_CLEAR;
    else if (stall)  return IFID_HOLD;
    else if (!ready) return IFID_CLEAR;
    else             return IFID_LOAD;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush > stall > bubble > load.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int          XLEN      = XLEN_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_flush,
  input  logic            i_stall,
  input  logic            i_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus,
  input  logic            i_fault,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus,
  output logic            o_valid,
  output logic            o_fault
);

  ifid_op_e w_op;

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus;
  logic            r_valid;
  logic            r_fault;

  always_comb begin
    w_op = ifid_op(i_flush, i_stall, i_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr   <= NOP_INSTR;
      r_pc      <= '0;
      r_pc_plus <= '0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      unique case (w_op)
        IFID_CLEAR: begin
          r_instr   <= NOP_INSTR;
          r_pc      <= '0;
          r_pc_plus <= '0;
          r_valid   <= 1'b0;
          r_fault   <= 1'b0;
        end
        IFID_LOAD: begin
          r_instr   <= i_instr;
          r_pc      <= i_pc;
          r_pc_plus <= i_pc_plus;
          r_valid   <= 1'b1;
          r_fault   <= i_fault;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_instr   = r_instr;
  assign o_pc      = r_pc;
  assign o_pc_plus = r_pc_plus;
  assign o_valid   = r_valid;
  assign o_fault   = r_fault;

endmodule

// File: rtl/fetch_pipe.sv
// Fetch stage: PC register, PC+step adder, redirect mux and IF/ID register.
module fetch_pipe
  import riscv_pkg::*;
#(
  parameter int             XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int             PC_STEP   = PC_STEP_DEF,
  parameter logic [31:0]    NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FaultD
);

  logic [XLEN-1:0] r_pcf;
  logic            r_fault_f;
  logic [XLEN-1:0] w_pc_plus_f;
  logic [XLEN-1:0] w_pc_next;
  logic            w_fault_next;

  assign w_pc_plus_f = r_pcf + XLEN'(PC_STEP);
  assign imem_addr   = r_pcf;
  assign imem_req    = !rst && !StallF;

  // Redirect overrides stall; the low target bits only raise a fault flag.
  always_comb begin
    w_pc_next    = r_pcf;
    w_fault_next = r_fault_f;
    if (PCSrcE) begin
      w_pc_next    = {PCTargetE[XLEN-1:2], 2'b00};
      w_fault_next = |PCTargetE[1:0];
    end else if (!StallF && imem_ready) begin
      w_pc_next    = w_pc_plus_f;
      w_fault_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcf     <= RESET_PC;
      r_fault_f <= 1'b0;
    end else begin
      r_pcf     <= w_pc_next;
      r_fault_f <= w_fault_next;
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (FlushD | PCSrcE),
    .i_stall   (StallF),
    .i_ready   (imem_ready),
    .i_instr   (imem_rdata),
    .i_pc      (r_pcf),
    .i_pc_plus (w_pc_plus_f),
    .i_fault   (r_fault_f),
    .o_instr   (InstrD),
    .o_pc      (PCD),
    .o_pc_plus (PCPlus4D),
    .o_valid   (ValidD),
    .o_fault   (FaultD)
  );

endmodule

// File: tb/tb_fetch_pipe.sv
// Directed bench for fetch_pipe against hand-computed expectations.
module tb_fetch_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b1;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        FaultD;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory word i holds 0x100 + i.
  assign imem_rdata = 32'h100 + {2'b00, imem_addr[31:2]};

  fetch_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FaultD     (FaultD)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d(input string tag, input logic [31:0] instr,
                       input logic [31:0] pc, input logic v,
                       input logic f);
    chk({tag, ".instr"}, InstrD, instr);
    chk({tag, ".pcd"}, PCD, pc);
    chk({tag, ".valid"}, {31'b0, ValidD}, {31'b0, v});
    chk({tag, ".fault"}, {31'b0, FaultD}, {31'b0, f});
  endtask

  initial begin
    tick();
    chk_d("rst", 32'h13, 32'h0, 1'b0, 1'b0);
    chk("rst.p4d", PCPlus4D, 32'h0);
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.req", {31'b0, imem_req}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("go.req", {31'b0, imem_req}, 32'h1);
    chk("go.addr", imem_addr, 32'h0);

    tick();
    chk_d("seq0", 32'h100, 32'h0, 1'b1, 1'b0);
    chk("seq0.p4d", PCPlus4D, 32'h4);
    tick();
    chk_d("seq1", 32'h101, 32'h4, 1'b1, 1'b0);
    chk("seq1.p4d", PCPlus4D, 32'h8);
    chk("seq1.pcf", imem_addr, 32'h8);

    StallF = 1'b1;
    #1;
    chk("stall.req", {31'b0, imem_req}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_d("stall", 32'h101, 32'h4, 1'b1, 1'b0);
      chk("stall.pcf", imem_addr, 32'h8);
    end
    StallF = 1'b0;
    tick();
    chk_d("unstall", 32'h102, 32'h8, 1'b1, 1'b0);
    chk("unstall.pcf", imem_addr, 32'hC);

    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_d("wait", 32'h13, 32'h0, 1'b0, 1'b0);
      chk("wait.pcf", imem_addr, 32'hC);
    end
    imem_ready = 1'b1;
    tick();
    chk_d("waitdone", 32'h103, 32'hC, 1'b1, 1'b0);
    chk("waitdone.pcf", imem_addr, 32'h10);

    PCSrcE = 1'b1;
    PCTargetE = 32'h40;
    StallF = 1'b1;
    tick();
    PCSrcE = 1'b0;
    StallF = 1'b0;
    chk_d("redir", 32'h13, 32'h0, 1'b0, 1'b0);
    chk("redir.pcf", imem_addr, 32'h40);
    tick();
    chk_d("tgt", 32'h110, 32'h40, 1'b1, 1'b0);
    chk("tgt.p4d", PCPlus4D, 32'h44);

    PCSrcE = 1'b1;
    PCTargetE = 32'h42;
    tick();
    PCSrcE = 1'b0;
    chk("mis.pcf", imem_addr, 32'h40);
    chk("mis.valid", {31'b0, ValidD}, 32'h0);
    tick();
    chk_d("mis", 32'h110, 32'h40, 1'b1, 1'b1);
    tick();
    chk_d("mis.next", 32'h111, 32'h44, 1'b1, 1'b0);

    FlushD = 1'b1;
    StallF = 1'b1;
    tick();
    FlushD = 1'b0;
    StallF = 1'b0;
    chk_d("flst", 32'h13, 32'h0, 1'b0, 1'b0);
    chk("flst.pcf", imem_addr, 32'h48);
    tick();
    chk_d("flst.next", 32'h112, 32'h48, 1'b1, 1'b0);

    PCSrcE = 1'b1;
    PCTargetE = 32'hFFFF_FFFC;
    imem_ready = 1'b0;
    tick();
    PCSrcE = 1'b0;
    imem_ready = 1'b1;
    chk("wrap.pcf", imem_addr, 32'hFFFF_FFFC);
    chk("wrap.valid", {31'b0, ValidD}, 32'h0);
    tick();
    chk_d("wrap", 32'h4000_00FF, 32'hFFFF_FFFC, 1'b1, 1'b0);
    chk("wrap.p4d", PCPlus4D, 32'h0);
    chk("wrap.nextpc", imem_addr, 32'h0);
    tick();
    chk_d("wrap.next", 32'h100, 32'h0, 1'b1, 1'b0);

    #2;
    rst = 1'b1;
    #1;
    chk_d("midrst", 32'h13, 32'h0, 1'b0, 1'b0);
    chk("midrst.p4d", PCPlus4D, 32'h0);
    chk("midrst.addr", imem_addr, 32'h0);
    chk("midrst.req", {31'b0, imem_req}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
